// File: rtl/vga_line_fetch.sv
// Frame-buffer read scheduler: issues burst reads over req/ack and buffers the
// returned pixels in a show-ahead FIFO that feeds the VGA display pipeline.
module vga_line_fetch #(
    parameter int unsigned   HDISP      = 800,
    parameter int unsigned   VDISP      = 480,
    parameter int unsigned   BURST      = 16,
    parameter int unsigned   FIFO_DEPTH = 64,
    parameter int unsigned   AW         = 32,
    parameter logic [AW-1:0] BASE       = '0
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          frame_start,
    input  logic          pix_rd,
    output logic [23:0]   pix_data,
    output logic          pix_valid,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [23:0]   mem_rdata,
    input  logic          mem_rvalid,
    output logic          underflow
);

    localparam int unsigned TOTAL = HDISP * VDISP;
    localparam int unsigned PW    = $clog2(TOTAL + 1);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTRW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BW    = $clog2(BURST + 1);

    typedef enum logic [2:0] {StIdle, StReq, StData, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   p_q, p_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            req_q, req_d;
    logic            flush, push, pop, last_beat, space_ok;

    logic [23:0]     fifo_mem [FIFO_DEPTH];
    logic [CW-1:0]   count_q;
    logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
    logic [23:0]     hold_q;
    logic            underflow_q;

    assign last_beat = (beat_q == BW'(BURST - 1));
    assign space_ok  = (CW'(FIFO_DEPTH) - count_q) >= CW'(BURST);
    assign pop       = pix_rd && (count_q != '0);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        beat_d  = beat_q;
        req_d   = req_q;
        flush   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (frame_start) begin
                    flush   = 1'b1;
                    p_d     = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (req_q && mem_ack) begin
                    // An accepted burst must still be drained even if a restart arrives now.
                    req_d   = 1'b0;
                    p_d     = p_q + PW'(BURST);
                    beat_d  = '0;
                    state_d = frame_start ? StDrain : StData;
                end else if (frame_start) begin
                    req_d = 1'b0;
                    flush = 1'b1;
                    p_d   = '0;
                end else if (!req_q && space_ok) begin
                    req_d = 1'b1;
                end
            end
            StData: begin
                if (mem_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    push   = !frame_start;
                    if (last_beat) begin
                        if (frame_start) begin
                            flush   = 1'b1;
                            p_d     = '0;
                            state_d = StReq;
                        end else begin
                            state_d = (p_q == PW'(TOTAL)) ? StDone : StReq;
                        end
                    end else if (frame_start) begin
                        state_d = StDrain;
                    end
                end else if (frame_start) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        flush   = 1'b1;
                        p_d     = '0;
                        state_d = StReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            beat_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            beat_q  <= beat_d;
            req_q   <= req_d;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (pix_rd && (count_q == '0)) begin
                underflow_q <= 1'b1;
            end
            if (flush) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                hold_q   <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    hold_q   <= fifo_mem[rd_ptr_q];
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    // When empty, the last popped pixel (or zero after flush/reset) stays on the bus.
    assign pix_data  = (count_q != '0) ? fifo_mem[rd_ptr_q] : hold_q;
    assign pix_valid = (count_q != '0);
    assign mem_req   = req_q;
    assign mem_addr  = BASE + (AW'(p_q) << 2);
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized bench for vga_line_fetch: a transaction-level model of the frame
// scan and pixel queue predicts every output cycle by cycle.
module tb_vga_line_fetch;

    localparam int unsigned HDISP      = 8;
    localparam int unsigned VDISP      = 2;
    localparam int unsigned BURST      = 4;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned AW         = 32;
    localparam logic [31:0] BASE       = 32'h0;
    localparam int          TOTAL      = HDISP * VDISP;

    logic        pixel_clk   = 1'b0;
    logic        pixel_rst   = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_rd      = 1'b0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack     = 1'b0;
    logic [23:0] mem_rdata   = '0;
    logic        mem_rvalid  = 1'b0;
    logic        underflow;

    vga_line_fetch #(
        .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH),
        .AW(AW), .BASE(BASE)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .frame_start(frame_start),
        .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .underflow(underflow)
    );

    always #5 pixel_clk = ~pixel_clk;

    logic [23:0] fb [TOTAL];
    logic [23:0] exp_q [$];
    logic [31:0] acc_addrs [$];
    logic [31:0] prev_addr;
    int next_p, beats_left, cur_p, ack_wait, ack_delay, beat_pct, n_out, req_hi;
    bit armed, outstanding, pending, uf, zero_head, prev_hold, prev_drop;
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        next_p = 0; beats_left = 0; cur_p = 0; ack_wait = 0;
        armed = 0; outstanding = 0; pending = 0; uf = 0; zero_head = 1;
        prev_hold = 0; prev_drop = 0;
    endtask

    task automatic model_flush();
        exp_q.delete();
        next_p = 0;
        zero_head = 1;
    endtask

    task automatic check_outputs();
        check("pix_valid", 32'(pix_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("pix_data", 32'(pix_data), 32'(exp_q[0]));
        else if (zero_head) check("pix_data_zero", 32'(pix_data), 32'h0);
        check("underflow", 32'(underflow), 32'(uf));
        if (mem_req) begin
            check("req_allowed", 32'(armed && !outstanding && next_p < TOTAL &&
                                     exp_q.size() <= FIFO_DEPTH - BURST), 32'h1);
            check("req_addr", mem_addr, BASE + 32'(4 * next_p));
        end
        if (prev_hold) begin
            check("req_stable", 32'(mem_req), 32'h1);
            check("addr_stable", mem_addr, prev_addr);
        end
        if (prev_drop) check("req_drop", 32'(mem_req), 32'h0);
    endtask

    // One clock: check outputs, drive inputs for the next edge, apply its effect to the model.
    task automatic step(input bit fs, input bit rd);
        bit ack, beat;
        logic [23:0] d;
        check_outputs();
        ack = 1'b0; beat = 1'b0; d = 24'($urandom);
        if (mem_req) begin
            req_hi++;
            if (ack_wait >= ack_delay) ack = 1'b1;
            else ack_wait++;
        end else begin
            ack_wait = 0;
        end
        if (outstanding && beats_left > 0 && !fs && int'($urandom_range(99)) < beat_pct) begin
            beat = 1'b1;
            d = fb[cur_p + BURST - beats_left];
        end
        prev_hold = mem_req && !ack && !fs;
        prev_drop = mem_req && !ack && fs;
        prev_addr = mem_addr;
        frame_start = fs; pix_rd = rd; mem_ack = ack; mem_rvalid = beat; mem_rdata = d;

        if (rd) begin
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_out++;
                zero_head = 0;
            end else begin
                uf = 1;
            end
        end
        if (ack) begin
            acc_addrs.push_back(mem_addr);
            outstanding = 1; beats_left = BURST; cur_p = next_p;
            next_p += BURST; ack_wait = 0;
        end
        if (fs) begin
            armed = 1;
            if (outstanding) pending = 1;
            else model_flush();
        end
        if (beat) begin
            beats_left--;
            if (!pending) begin
                check("fifo_room", 32'(exp_q.size() < FIFO_DEPTH), 32'h1);
                exp_q.push_back(d);
            end
            if (beats_left == 0) begin
                outstanding = 0;
                if (pending) begin
                    pending = 0;
                    model_flush();
                end
            end
        end
        @(posedge pixel_clk);
        @(negedge pixel_clk);
    endtask

    task automatic do_reset();
        frame_start = 0; pix_rd = 0; mem_ack = 0; mem_rvalid = 0;
        pixel_rst = 1;
        model_reset();
        repeat (2) @(negedge pixel_clk);
        pixel_rst = 0;
        @(negedge pixel_clk);
    endtask

    initial begin
        for (int i = 0; i < TOTAL; i++) fb[i] = 24'($urandom);
        ack_delay = 0; beat_pct = 100; n_out = 0; req_hi = 0;
        do_reset();
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_addr", mem_addr, BASE);
        check("rst_valid", 32'(pix_valid), 32'h0);
        check("rst_data", 32'(pix_data), 32'h0);
        check("rst_uf", 32'(underflow), 32'h0);

        // Fill with no display reads: two bursts, then stall on full FIFO.
        step(1, 0);
        repeat (30) step(0, 0);
        check("fill_nreq", 32'(acc_addrs.size()), 32'd2);
        for (int i = 0; i < acc_addrs.size() && i < 2; i++)
            check("fill_addr", acc_addrs[i], BASE + 32'(16 * i));
        check("fill_valid", 32'(pix_valid), 32'h1);
        check("fill_head", 32'(pix_data), 32'(fb[0]));
        check("fill_req_low", 32'(mem_req), 32'h0);

        // Read whenever data is available until the whole frame is out.
        n_out = 0;
        for (int i = 0; i < 300 && n_out < TOTAL; i++) step(0, exp_q.size() != 0);
        repeat (10) step(0, 0);
        check("frame_pixels", 32'(n_out), 32'(TOTAL));
        check("frame_nreq", 32'(acc_addrs.size()), 32'd4);
        for (int i = 0; i < acc_addrs.size() && i < 4; i++)
            check("frame_addr", acc_addrs[i], BASE + 32'(16 * i));
        check("frame_uf", 32'(underflow), 32'h0);
        check("done_req_low", 32'(mem_req), 32'h0);

        // Slow acknowledge: request held six cycles per burst.
        ack_delay = 5; acc_addrs.delete(); req_hi = 0;
        step(1, 0);
        repeat (40) step(0, 0);
        check("slow_nacc", 32'(acc_addrs.size()), 32'd2);
        check("slow_req_cycles", 32'(req_hi), 32'd12);
        check("slow_head", 32'(pix_data), 32'(fb[0]));

        // Restart after two beats of the burst at 0x10.
        ack_delay = 0;
        step(1, 0);
        for (int i = 0; i < 60 && !(outstanding && cur_p == BURST && beats_left == BURST - 2); i++)
            step(0, 0);
        check("mid_burst_reached", 32'(outstanding && cur_p == BURST && beats_left == BURST - 2),
              32'h1);
        step(1, 0);
        for (int i = 0; i < 20 && outstanding; i++) step(0, 0);
        check("restart_empty", 32'(pix_valid), 32'h0);
        check("restart_data0", 32'(pix_data), 32'h0);
        acc_addrs.delete();
        for (int i = 0; i < 20 && acc_addrs.size() == 0; i++) step(0, 0);
        check("restart_nacc", 32'(acc_addrs.size()), 32'd1);
        if (acc_addrs.size() != 0) check("restart_addr", acc_addrs[0], BASE);
        for (int i = 0; i < 20 && !pix_valid; i++) step(0, 0);
        check("restart_head", 32'(pix_data), 32'(fb[0]));

        // Sticky underflow across a new frame.
        do_reset();
        step(0, 1);
        step(0, 0);
        check("uf_set", 32'(underflow), 32'h1);
        step(1, 0);
        repeat (12) step(0, exp_q.size() != 0);
        check("uf_sticky", 32'(underflow), 32'h1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 40 && !(outstanding && beats_left > 0 && beats_left < BURST); i++)
            step(0, exp_q.size() != 0);
        check("in_data_reached", 32'(outstanding && beats_left > 0 && beats_left < BURST), 32'h1);
        frame_start = 0; pix_rd = 0; mem_ack = 0; mem_rvalid = 0;
        #2 pixel_rst = 1;
        model_reset();
        #1;
        check("arst_req", 32'(mem_req), 32'h0);
        check("arst_addr", mem_addr, BASE);
        check("arst_valid", 32'(pix_valid), 32'h0);
        check("arst_data", 32'(pix_data), 32'h0);
        check("arst_uf", 32'(underflow), 32'h0);
        @(negedge pixel_clk);
        pixel_rst = 0;
        acc_addrs.delete();
        repeat (10) step(0, 0);
        check("arst_no_req", 32'(acc_addrs.size()), 32'd0);

        // Random soak.
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                ack_delay = $urandom_range(0, 4);
                beat_pct = $urandom_range(30, 100);
            end
            step($urandom_range(149) == 0, $urandom_range(99) < 60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
